// File: rtl/result_converter_pipe.sv
// Two-stage CORDIC quadrant correction with saturating negation, optional narrowing and
// valid/ready handshake. Build option RESULT_CONVERTER_ROUND_EN selects round-to-nearest narrowing.
module result_converter_pipe #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  flip,
  input  logic signed [WIDTH-1:0]     sin_in,
  input  logic signed [WIDTH-1:0]     cos_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] sin_out,
  output logic signed [OUT_WIDTH-1:0] cos_out,
  output logic [2:0]                  flip_out,
  output logic                        err_out,
  output logic [CNT_WIDTH-1:0]        err_count,
  output logic [CNT_WIDTH-1:0]        sample_count
);

  localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MaxVal = ~MinVal;
  localparam int Sh = int'(WIDTH) - int'(OUT_WIDTH);

`ifdef RESULT_CONVERTER_ROUND_EN
  localparam int HalfSh = (Sh > 0) ? Sh - 1 : 0;
  localparam logic signed [WIDTH:0] Half   = (Sh > 0) ? ((WIDTH+1)'(1) << HalfSh) : '0;
  localparam logic signed [WIDTH:0] HalfM1 = (Sh > 0) ? Half - 1 : '0;
  localparam logic signed [WIDTH:0] OutMaxExt = ((WIDTH+1)'(1) << (OUT_WIDTH - 1)) - 1;
  localparam logic signed [WIDTH:0] OutMinExt = -OutMaxExt - 1;
`endif

  function automatic logic signed [WIDTH-1:0] neg(input logic signed [WIDTH-1:0] x);
    return (x == MinVal) ? MaxVal : -x;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] reduce(input logic signed [WIDTH-1:0] x);
`ifdef RESULT_CONVERTER_ROUND_EN
    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] shifted;
    // Smaller bias for negatives makes ties round away from zero.
    sum     = {x[WIDTH-1], x} + (x[WIDTH-1] ? HalfM1 : Half);
    shifted = sum >>> Sh;
    if (shifted > OutMaxExt) return OutMaxExt[OUT_WIDTH-1:0];
    if (shifted < OutMinExt) return OutMinExt[OUT_WIDTH-1:0];
    return shifted[OUT_WIDTH-1:0];
`else
    return x[WIDTH-1 -: OUT_WIDTH];
`endif
  endfunction

  logic                        alive_q;
  logic                        s1_valid_q, s1_err_q;
  logic signed [WIDTH-1:0]     s1_sin_q, s1_cos_q;
  logic [2:0]                  s1_flip_q;
  logic                        s2_valid_q, s2_err_q;
  logic signed [OUT_WIDTH-1:0] s2_sin_q, s2_cos_q;
  logic [2:0]                  s2_flip_q;
  logic [CNT_WIDTH-1:0]        err_cnt_q, smp_cnt_q;

  logic                    s2_load, in_fire, out_fire;
  logic signed [WIDTH-1:0] fold_sin, fold_cos;
  logic                    fold_err;

  always_comb begin
    fold_sin = '0;
    fold_cos = '0;
    fold_err = 1'b0;
    case (flip)
      3'b000:         begin fold_sin = sin_in;      fold_cos = cos_in;      end
      3'b001:         begin fold_sin = neg(cos_in); fold_cos = sin_in;      end
      3'b111:         begin fold_sin = cos_in;      fold_cos = neg(sin_in); end
      3'b010, 3'b110: begin fold_sin = neg(sin_in); fold_cos = neg(cos_in); end
      default:        fold_err = 1'b1;
    endcase
  end

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    in_ready = alive_q && (!s1_valid_q || s2_load);
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_sin_q   <= '0;
      s1_cos_q   <= '0;
      s1_flip_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_sin_q   <= '0;
      s2_cos_q   <= '0;
      s2_flip_q  <= '0;
      err_cnt_q  <= '0;
      smp_cnt_q  <= '0;
    end else begin
      alive_q <= 1'b1;
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sin_q  <= reduce(s1_sin_q);
          s2_cos_q  <= reduce(s1_cos_q);
          s2_flip_q <= s1_flip_q;
          s2_err_q  <= s1_err_q;
        end
      end
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_sin_q   <= fold_sin;
        s1_cos_q   <= fold_cos;
        s1_flip_q  <= flip;
        s1_err_q   <= fold_err;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
      if (in_fire && fold_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      if (out_fire) smp_cnt_q <= smp_cnt_q + 1'b1;
    end
  end

  assign out_valid    = s2_valid_q;
  assign sin_out      = s2_sin_q;
  assign cos_out      = s2_cos_q;
  assign flip_out     = s2_flip_q;
  assign err_out      = s2_err_q;
  assign err_count    = err_cnt_q;
  assign sample_count = smp_cnt_q;

endmodule

// File: tb/tb_result_converter_pipe.sv
// Directed bench: a 16->16 instance and a 16->8 instance share all inputs.
module tb_result_converter_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, out_ready;
  logic [2:0]  flip;
  logic [15:0] sin_in, cos_in;
  logic        in_ready, out_valid, err_out;
  logic [15:0] sin_out, cos_out;
  logic [2:0]  flip_out;
  logic [7:0]  err_count, sample_count;
  logic        in_ready8, out_valid8, err_out8;
  logic [7:0]  sin_out8, cos_out8;
  logic [2:0]  flip_out8;
  logic [7:0]  err_count8, sample_count8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  result_converter_pipe #(.WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flip(flip),
    .sin_in(sin_in), .cos_in(cos_in), .out_valid(out_valid), .out_ready(out_ready),
    .sin_out(sin_out), .cos_out(cos_out), .flip_out(flip_out), .err_out(err_out),
    .err_count(err_count), .sample_count(sample_count)
  );

  result_converter_pipe #(.WIDTH(16), .OUT_WIDTH(8), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .flip(flip),
    .sin_in(sin_in), .cos_in(cos_in), .out_valid(out_valid8), .out_ready(out_ready),
    .sin_out(sin_out8), .cos_out(cos_out8), .flip_out(flip_out8), .err_out(err_out8),
    .err_count(err_count8), .sample_count(sample_count8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    step();
  endtask

  // One sample through an otherwise idle pipe with out_ready=1: result after two edges.
  task automatic send_one(input string tag, input logic [2:0] f, input logic [15:0] s,
                          input logic [15:0] c, input logic [15:0] es, input logic [15:0] ec,
                          input logic ee, input logic [7:0] e8s, input logic [7:0] e8c);
    out_ready = 1'b1;
    flip = f; sin_in = s; cos_in = c; in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk({tag, " lat1 out_valid"}, 32'(out_valid), 32'h0);
    step();
    chk({tag, " out_valid"}, 32'(out_valid), 32'h1);
    chk({tag, " sin"}, 32'(sin_out), 32'(es));
    chk({tag, " cos"}, 32'(cos_out), 32'(ec));
    chk({tag, " flip_out"}, 32'(flip_out), 32'(f));
    chk({tag, " err_out"}, 32'(err_out), 32'(ee));
    chk({tag, " sin8"}, 32'(sin_out8), 32'(e8s));
    chk({tag, " cos8"}, 32'(cos_out8), 32'(e8c));
  endtask

  initial begin
    int sent, got;
    logic fire_in, fire_out;
    logic [7:0] exp8_cos, exp8_neg;
`ifdef RESULT_CONVERTER_ROUND_EN
    exp8_cos = 8'h02;
    exp8_neg = 8'h00;
`else
    exp8_cos = 8'h01;
    exp8_neg = 8'hFF;
`endif
    in_valid = 1'b0; out_ready = 1'b1; flip = 3'b000; sin_in = '0; cos_in = '0;
    rst = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset sin_out", 32'(sin_out), 32'h0);
    chk("reset err_count", 32'(err_count), 32'h0);
    chk("reset sample_count", 32'(sample_count), 32'h0);
    step();
    step();
    chk("held reset in_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'h0);
    step();
    chk("first clk in_ready", 32'(in_ready), 32'h1);

    send_one("q0",  3'b000, 16'h2000, 16'h6000, 16'h2000, 16'h6000, 1'b0, 8'h20, 8'h60);
    send_one("q+1", 3'b001, 16'h2000, 16'h6000, 16'hA000, 16'h2000, 1'b0, 8'hA0, 8'h20);
    send_one("q-1", 3'b111, 16'h2000, 16'h6000, 16'h6000, 16'hE000, 1'b0, 8'h60, 8'hE0);
    send_one("q+2", 3'b010, 16'h2000, 16'h6000, 16'hE000, 16'hA000, 1'b0, 8'hE0, 8'hA0);
    send_one("q-2", 3'b110, 16'h2000, 16'h6000, 16'hE000, 16'hA000, 1'b0, 8'hE0, 8'hA0);
    send_one("sat", 3'b010, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 8'h7F, 8'h7F);
    send_one("ill3", 3'b011, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b1, 8'h00, 8'h00);
    send_one("ill4", 3'b100, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b1, 8'h00, 8'h00);
    chk("err_count 2", 32'(err_count), 32'h2);
    send_one("narrow", 3'b000, 16'h7FFF, 16'h0180, 16'h7FFF, 16'h0180, 1'b0, 8'h7F, exp8_cos);
    send_one("narrow neg", 3'b000, 16'h0000, 16'hFFC0, 16'h0000, 16'hFFC0, 1'b0, 8'h00,
             exp8_neg);

    // Continuous stream of illegal codes; err_count must stick at all-ones.
    flip = 3'b011; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    step();
    step();
    chk("err_count sat", 32'(err_count), 32'hFF);

    // Reset with two samples held in the pipe.
    do_reset();
    out_ready = 1'b0; flip = 3'b000; sin_in = 16'h1111; cos_in = 16'h2222; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("pre-reset out_valid", 32'(out_valid), 32'h1);
    rst = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async sin_out", 32'(sin_out), 32'h0);
    chk("async err_count", 32'(err_count), 32'h0);
    chk("async sample_count", 32'(sample_count), 32'h0);
    chk("async in_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    step();
    send_one("post-reset", 3'b000, 16'h0300, 16'h0500, 16'h0300, 16'h0500, 1'b0, 8'h03, 8'h05);

    // Backpressure: out_ready low for the first six cycles, then a scoreboarded drain.
    do_reset();
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      in_valid = (sent < 5);
      flip = 3'b000;
      sin_in = 16'h0011 + 16'(sent);
      cos_in = 16'h0F00 + 16'(sent);
      out_ready = (cyc >= 6);
      #1;
      if (cyc == 2) chk("bp in_ready low", 32'(in_ready), 32'h0);
      if (cyc >= 3 && cyc < 6) chk("bp held sin", 32'(sin_out), 32'h0011);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        chk("bp order sin", 32'(sin_out), 32'(16'h0011 + 16'(got)));
        chk("bp order cos", 32'(cos_out), 32'(16'h0F00 + 16'(got)));
        got++;
      end
      if (cyc == 5) chk("bp accepted while stalled", 32'(sent), 32'd2);
      step();
      if (fire_in) sent++;
    end
    in_valid = 1'b0;
    chk("bp received", 32'(got), 32'd5);
    chk("bp sent", 32'(sent), 32'd5);
    step();
    chk("bp sample_count", 32'(sample_count), 32'd5);
    chk("bp drained", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
